// File: rtl/mmio_controller_if.sv
// CPU data-port and data-memory bus bundle seen by the MMIO controller.
// The master side is the cpu plus memory; the slave side is the controller.
interface mmio_controller_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] cpu_address;
  logic [DATA_WIDTH-1:0] cpu_write_data;
  logic                  cpu_write_enable;
  logic [DATA_WIDTH-1:0] cpu_read_data;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_write_data;
  logic                  mem_write_enable;
  logic [DATA_WIDTH-1:0] mem_read_data;

  modport master (
    output cpu_address, cpu_write_data, cpu_write_enable, mem_read_data,
    input  cpu_read_data, mem_address, mem_write_data, mem_write_enable
  );

  modport slave (
    input  cpu_address, cpu_write_data, cpu_write_enable, mem_read_data,
    output cpu_read_data, mem_address, mem_write_data, mem_write_enable
  );
endinterface

// File: rtl/mmio_controller.sv
// Memory-mapped I/O controller: debounced input banks, output registers,
// edge status with W1C and masked interrupt; other accesses pass to memory.
module mmio_controller #(
  parameter int unsigned           DATA_WIDTH      = 16,
  parameter int unsigned           ADDR_WIDTH      = 16,
  parameter logic [ADDR_WIDTH-1:0] IO_BASE         = 16'hFF00,
  parameter int unsigned           NUM_IN          = 2,
  parameter int unsigned           IN_WIDTH        = 10,
  parameter int unsigned           NUM_OUT         = 2,
  parameter int unsigned           DEBOUNCE_CYCLES = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  mmio_controller_if.slave              bus,
  input  logic [NUM_IN*IN_WIDTH-1:0]    in_ports,
  output logic [NUM_OUT*DATA_WIDTH-1:0] out_ports,
  output logic                          irq
);

  localparam int unsigned           CNT_W      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] OFF_OUT    = ADDR_WIDTH'(16);
  localparam logic [ADDR_WIDTH-1:0] OFF_STATUS = ADDR_WIDTH'(32);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK   = ADDR_WIDTH'(33);

  // Address decode and memory passthrough
  logic                  io_hit;
  logic                  io_we;
  logic [ADDR_WIDTH-1:0] offset;

  assign io_hit = (bus.cpu_address >= IO_BASE);
  assign offset = bus.cpu_address - IO_BASE;
  assign io_we  = bus.cpu_write_enable & io_hit;

  assign bus.mem_address      = bus.cpu_address;
  assign bus.mem_write_data   = bus.cpu_write_data;
  assign bus.mem_write_enable = bus.cpu_write_enable & ~io_hit;

  // Input synchronizers and debounce
  logic [IN_WIDTH-1:0] sync_a [NUM_IN];
  logic [IN_WIDTH-1:0] sync_b [NUM_IN];
  logic [IN_WIDTH-1:0] stable [NUM_IN];
  logic [CNT_W-1:0]    cnt    [NUM_IN];
  logic [NUM_IN-1:0]   accept;

  always_comb begin
    accept = '0;
    for (int unsigned i = 0; i < NUM_IN; i++)
      accept[i] = (sync_b[i] != stable[i]) && (cnt[i] == CNT_LAST);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_IN; i++) begin
        sync_a[i] <= '0;
        sync_b[i] <= '0;
        stable[i] <= '0;
        cnt[i]    <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_IN; i++) begin
        sync_a[i] <= in_ports[i*IN_WIDTH +: IN_WIDTH];
        sync_b[i] <= sync_a[i];
        if (sync_b[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          stable[i] <= sync_b[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Register write decode
  logic [DATA_WIDTH-1:0] out_q [NUM_OUT];
  logic [NUM_OUT-1:0]    out_we;
  logic                  status_we;
  logic                  mask_we;
  logic [NUM_IN-1:0]     status_q;
  logic [NUM_IN-1:0]     status_clr;
  logic [NUM_IN-1:0]     status_d;
  logic [NUM_IN-1:0]     mask_q;

  always_comb begin
    out_we = '0;
    for (int unsigned j = 0; j < NUM_OUT; j++)
      out_we[j] = io_we && (offset == OFF_OUT + ADDR_WIDTH'(j));
    status_we = io_we && (offset == OFF_STATUS);
    mask_we   = io_we && (offset == OFF_MASK);
  end

  // A new edge in the same cycle as a W1C keeps its status bit set.
  assign status_clr = status_we ? NUM_IN'(bus.cpu_write_data) : '0;
  assign status_d   = (status_q & ~status_clr) | accept;

  // Read mux; unmapped offsets fall through to zero
  logic [DATA_WIDTH-1:0] rd_data_d;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_io_q;

  always_comb begin
    rd_data_d = '0;
    for (int unsigned i = 0; i < NUM_IN; i++)
      if (offset == ADDR_WIDTH'(i)) rd_data_d = DATA_WIDTH'(stable[i]);
    for (int unsigned j = 0; j < NUM_OUT; j++)
      if (offset == OFF_OUT + ADDR_WIDTH'(j)) rd_data_d = out_q[j];
    if (offset == OFF_STATUS) rd_data_d = DATA_WIDTH'(status_q);
    if (offset == OFF_MASK)   rd_data_d = DATA_WIDTH'(mask_q);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int unsigned j = 0; j < NUM_OUT; j++) out_q[j] <= '0;
      status_q  <= '0;
      mask_q    <= '0;
      irq       <= 1'b0;
      rd_io_q   <= 1'b0;
      rd_data_q <= '0;
    end else begin
      for (int unsigned j = 0; j < NUM_OUT; j++)
        if (out_we[j]) out_q[j] <= bus.cpu_write_data;
      if (mask_we) mask_q <= NUM_IN'(bus.cpu_write_data);
      status_q  <= status_d;
      irq       <= |(status_q & mask_q);
      rd_io_q   <= io_hit;
      rd_data_q <= rd_data_d;
    end
  end

  assign bus.cpu_read_data = rd_io_q ? rd_data_q : bus.mem_read_data;

  always_comb begin
    out_ports = '0;
    for (int unsigned j = 0; j < NUM_OUT; j++)
      out_ports[j*DATA_WIDTH +: DATA_WIDTH] = out_q[j];
  end

endmodule

// File: tb/tb_mmio_controller.sv
// Directed self-checking bench for mmio_controller with a small sync-read
// memory model behind the passthrough port.
module tb_mmio_controller;
  localparam int unsigned DW   = 16;
  localparam int unsigned AW   = 16;
  localparam int unsigned NI   = 2;
  localparam int unsigned IW   = 10;
  localparam int unsigned NO   = 2;
  localparam int unsigned DB   = 4;
  localparam logic [15:0] BASE = 16'hFF00;

  logic             clock = 1'b0;
  logic             reset;
  logic [NI*IW-1:0] in_ports;
  logic [NO*DW-1:0] out_ports;
  logic             irq;
  logic [15:0]      d;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  mmio_controller_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  mmio_controller #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IO_BASE(BASE), .NUM_IN(NI),
    .IN_WIDTH(IW), .NUM_OUT(NO), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus.slave),
    .in_ports(in_ports), .out_ports(out_ports), .irq(irq)
  );

  always #5 clock = ~clock;

  logic [15:0] mem [256];
  always @(posedge clock) begin
    if (bus.mem_write_enable) mem[bus.mem_address[7:0]] <= bus.mem_write_data;
    bus.mem_read_data <= mem[bus.mem_address[7:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input logic [15:0] a);
    bus.cpu_address      = a;
    bus.cpu_write_enable = 1'b0;
  endtask

  task automatic store(input logic [15:0] a, input logic [15:0] wd,
                       input logic exp_mwe, input string tag);
    bus.cpu_address      = a;
    bus.cpu_write_data   = wd;
    bus.cpu_write_enable = 1'b1;
    #1;
    check(tag, 32'(bus.mem_write_enable), 32'(exp_mwe));
    tick();
    bus.cpu_write_enable = 1'b0;
  endtask

  task automatic load(input logic [15:0] a, output logic [15:0] rd);
    idle(a);
    tick();
    rd = bus.cpu_read_data;
  endtask

  initial begin
    reset              = 1'b0;
    in_ports           = {10'h2AA, 10'h155};
    bus.cpu_write_data = '0;
    idle(BASE);
    repeat (3) tick();
    check("rst_out_ports", 32'(out_ports), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    reset = 1'b1;
    tick();
    check("rst_in0_first_read", 32'(bus.cpu_read_data), 32'h0);
    in_ports = '0;
    repeat (10) tick();

    // passthrough
    store(16'h0040, 16'h1234, 1'b1, "pt_mwe");
    load(16'h0040, d);
    check("pt_read", 32'(d), 32'h1234);
    store(16'h0030, 16'hBEEF, 1'b1, "pt2_mwe");
    store(16'hFEFF, 16'h5A5A, 1'b1, "below_base_mwe");
    load(16'hFEFF, d);
    check("below_base_read", 32'(d), 32'h5A5A);

    // output registers
    store(BASE + 16'h11, 16'hA5A5, 1'b0, "out1_mwe");
    check("out1_port", 32'(out_ports[31:16]), 32'hA5A5);
    check("out0_port", 32'(out_ports[15:0]), 32'h0);
    load(BASE + 16'h11, d);
    check("out1_read", 32'(d), 32'hA5A5);
    store(BASE + 16'h10, 16'h0F0F, 1'b0, "out0_mwe");
    load(BASE + 16'h10, d);
    check("out0_read", 32'(d), 32'h0F0F);

    // debounce: short pulse rejected, held level accepted after 2+DB edges
    idle(BASE);
    in_ports[9:0] = 10'h3FF;
    repeat (3) tick();
    in_ports[9:0] = 10'h000;
    repeat (8) tick();
    check("glitch_in0", 32'(bus.cpu_read_data), 32'h0);
    load(BASE + 16'h20, d);
    check("glitch_status", 32'(d), 32'h0);
    idle(BASE);
    in_ports[9:0] = 10'h3FF;
    repeat (6) tick();
    check("deb_not_yet", 32'(bus.cpu_read_data), 32'h0);
    tick();
    check("deb_in0", 32'(bus.cpu_read_data), 32'h3FF);
    check("nomask_irq", 32'(irq), 32'h0);
    store(BASE + 16'h20, 16'h0001, 1'b0, "w1c_mwe");
    load(BASE + 16'h20, d);
    check("w1c_status", 32'(d), 32'h0);

    // interrupt
    store(BASE + 16'h21, 16'hFFFF, 1'b0, "mask_mwe");
    load(BASE + 16'h21, d);
    check("mask_read", 32'(d), 32'h0003);
    store(BASE + 16'h21, 16'h0001, 1'b0, "mask1_mwe");
    idle(BASE + 16'h20);
    in_ports[9:0] = 10'h000;
    repeat (6) tick();
    check("irq_early", 32'(irq), 32'h0);
    tick();
    check("irq_status", 32'(bus.cpu_read_data), 32'h1);
    check("irq_set", 32'(irq), 32'h1);
    store(BASE + 16'h20, 16'h0001, 1'b0, "irq_w1c_mwe");
    check("irq_hold", 32'(irq), 32'h1);
    tick();
    check("irq_clear", 32'(irq), 32'h0);
    check("irq_status_clr", 32'(bus.cpu_read_data), 32'h0);

    // W1C coincident with a new edge
    in_ports[9:0] = 10'h3FF;
    repeat (5) tick();
    bus.cpu_address      = BASE + 16'h20;
    bus.cpu_write_data   = 16'h0001;
    bus.cpu_write_enable = 1'b1;
    tick();
    load(BASE + 16'h20, d);
    check("set_wins", 32'(d), 32'h1);
    check("set_wins_irq", 32'(irq), 32'h1);
    store(BASE + 16'h21, 16'h0000, 1'b0, "mask0_mwe");
    check("mask_irq_hold", 32'(irq), 32'h1);
    tick();
    check("mask_drop", 32'(irq), 32'h0);
    store(BASE + 16'h20, 16'h0001, 1'b0, "clr2_mwe");

    // unmapped and out-of-range offsets
    load(BASE + 16'h30, d);
    check("unm_read", 32'(d), 32'h0);
    store(BASE + 16'h30, 16'hFFFF, 1'b0, "unm_mwe");
    store(BASE + 16'h12, 16'h1234, 1'b0, "oor_out_mwe");
    check("unm_out_ports", 32'(out_ports), 32'hA5A50F0F);
    load(BASE + 16'h21, d);
    check("unm_mask", 32'(d), 32'h0);
    load(BASE + 16'h20, d);
    check("unm_status", 32'(d), 32'h0);
    load(BASE + 16'h02, d);
    check("oor_in_read", 32'(d), 32'h0);
    load(BASE + 16'h12, d);
    check("oor_out_read", 32'(d), 32'h0);
    load(16'h0030, d);
    check("unm_mem_intact", 32'(d), 32'hBEEF);
    check("unm_irq", 32'(irq), 32'h0);

    // bank 1
    in_ports[19:10] = 10'h155;
    repeat (7) tick();
    load(BASE + 16'h01, d);
    check("in1_read", 32'(d), 32'h155);
    load(BASE + 16'h20, d);
    check("status_b1", 32'(d), 32'h2);
    check("b1_irq_masked", 32'(irq), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
